// File: rtl/maria_bus_arbiter.sv
// maria_bus_arbiter: shared-bus owner between the 6502 and MARIA line DMA.
// Generates pclk0 with fast/slow stretching, runs HALT -> GRANT -> RELEASE,
// and holds cpu_ready low from a WSYNC write until the next line start.
// Ports:
//   sysclock, reset_b (async, active low)
//   sel_slow_clock : current CPU access targets slow memory
//   dma_req/dma_done : DMA engine request level / completion pulse
//   wsync_req, line_start : WSYNC strobe / video line start strobe
//   pclk0 : CPU phase enable pulse, halt_b : CPU HALT (active low)
//   drive_AB, dma_grant : MARIA owns the bus
//   cpu_ready : CPU RDY, dma_abort : timeout release pulse
//   dma_cycles : DMA sysclocks in the last completed line
// Option: define ARB_DMA_STATS_EN to build the per-line DMA cycle counter;
// without it dma_cycles is tied to zero.
module maria_bus_arbiter #(
  parameter int FAST_DIV    = 4,
  parameter int SLOW_DIV    = 6,
  parameter int HALT_LAT    = 2,
  parameter int DMA_TIMEOUT = 1024
) (
  input  logic        sysclock,
  input  logic        reset_b,
  input  logic        sel_slow_clock,
  input  logic        dma_req,
  input  logic        dma_done,
  input  logic        wsync_req,
  input  logic        line_start,
  output logic        pclk0,
  output logic        halt_b,
  output logic        drive_AB,
  output logic        dma_grant,
  output logic        cpu_ready,
  output logic        dma_abort,
  output logic [15:0] dma_cycles
);

  localparam int CW  = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
  localparam int HCW = (HALT_LAT > 1) ? $clog2(HALT_LAT) : 1;
  localparam int TW  = (DMA_TIMEOUT > 1) ? $clog2(DMA_TIMEOUT) : 1;

  localparam logic [CW-1:0]  FAST_TC = CW'(FAST_DIV - 1);
  localparam logic [CW-1:0]  SLOW_TC = CW'(SLOW_DIV - 1);
  localparam logic [HCW-1:0] HALT_TC = HCW'(HALT_LAT - 1);
  localparam logic [TW-1:0]  TMO_TC  = TW'(DMA_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_HALT, S_GRANT, S_REL
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  r_tc;
  logic [CW-1:0]  w_tc;
  logic           w_pclk;
  logic [HCW-1:0] r_hcnt;
  logic [TW-1:0]  r_tcnt;
  logic           r_abort;
  logic           w_abort_nxt;
  logic           r_ready;
  logic           w_halt_b;
  logic           w_drive;

  // The cycle length is chosen from the inputs seen while the counter
  // sits at zero; later sel_slow_clock changes wait for the next cycle.
  always_comb begin
    w_tc = r_tc;
    if (r_cnt == '0)
      w_tc = (sel_slow_clock && !w_drive) ? SLOW_TC : FAST_TC;
  end

  assign w_pclk = (r_cnt == w_tc);

  always_ff @(posedge sysclock or negedge reset_b) begin
    if (!reset_b) begin
      r_cnt <= '0;
      r_tc  <= FAST_TC;
    end else begin
      r_cnt <= w_pclk ? '0 : r_cnt + CW'(1);
      if (r_cnt == '0)
        r_tc <= w_tc;
    end
  end

  // State register
  always_ff @(posedge sysclock or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= S_IDLE;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_abort <= w_abort_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_abort_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (dma_req)
          w_state_nxt = S_HALT;
      end
      S_HALT: begin
        if (!dma_req)
          w_state_nxt = S_REL;
        else if (w_pclk && r_hcnt == HALT_TC)
          w_state_nxt = S_GRANT;
      end
      S_GRANT: begin
        if (dma_done || !dma_req) begin
          w_state_nxt = S_REL;
        end else if (r_tcnt == TMO_TC) begin
          w_state_nxt = S_REL;
          w_abort_nxt = 1'b1;
        end
      end
      S_REL: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode straight from the state register
  always_comb begin
    w_halt_b = 1'b1;
    w_drive  = 1'b0;
    unique case (r_state)
      S_IDLE:  w_halt_b = 1'b1;
      S_HALT:  w_halt_b = 1'b0;
      S_GRANT: begin
        w_halt_b = 1'b0;
        w_drive  = 1'b1;
      end
      S_REL:   w_halt_b = 1'b0;
    endcase
  end

  // Halt-latency and grant-timeout counters restart on state entry
  always_ff @(posedge sysclock or negedge reset_b) begin
    if (!reset_b) begin
      r_hcnt <= '0;
      r_tcnt <= '0;
    end else begin
      if (r_state != S_HALT)
        r_hcnt <= '0;
      else if (w_pclk)
        r_hcnt <= r_hcnt + HCW'(1);
      if (r_state != S_GRANT)
        r_tcnt <= '0;
      else
        r_tcnt <= r_tcnt + TW'(1);
    end
  end

  // WSYNC set dominates a same-cycle line start
  always_ff @(posedge sysclock or negedge reset_b) begin
    if (!reset_b)
      r_ready <= 1'b1;
    else if (wsync_req)
      r_ready <= 1'b0;
    else if (line_start)
      r_ready <= 1'b1;
  end

`ifdef ARB_DMA_STATS_EN
  logic [15:0] r_line_cnt;
  logic [15:0] r_dma_cycles;
  logic [15:0] w_line_inc;

  // Includes the DMA cycle of the current sysclock, saturating.
  assign w_line_inc = (w_drive && r_line_cnt != 16'hFFFF) ?
                      r_line_cnt + 16'd1 : r_line_cnt;

  always_ff @(posedge sysclock or negedge reset_b) begin
    if (!reset_b) begin
      r_line_cnt   <= 16'h0000;
      r_dma_cycles <= 16'h0000;
    end else if (line_start) begin
      r_dma_cycles <= w_line_inc;
      r_line_cnt   <= {15'd0, w_drive};
    end else begin
      r_line_cnt   <= w_line_inc;
    end
  end

  assign dma_cycles = r_dma_cycles;
`else
  assign dma_cycles = 16'h0000;
`endif

  assign pclk0     = w_pclk;
  assign halt_b    = w_halt_b;
  assign drive_AB  = w_drive;
  assign dma_grant = w_drive;
  assign cpu_ready = r_ready;
  assign dma_abort = r_abort;

endmodule

// File: tb/tb_maria_bus_arbiter.sv
// tb_maria_bus_arbiter: directed sequences, a cpu_ready vector table and
// random traffic checked every cycle against a behavioural model.
module tb_maria_bus_arbiter;

  localparam int FAST = 4;
  localparam int SLOW = 6;
  localparam int TMO  = 1024;

  localparam int P_IDLE  = 0;
  localparam int P_HALT  = 1;
  localparam int P_GRANT = 2;
  localparam int P_REL   = 3;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel   = 1'b0;
  logic        req   = 1'b0;
  logic        done  = 1'b0;
  logic        ws    = 1'b0;
  logic        ls    = 1'b0;
  logic        pclk0;
  logic        halt_b;
  logic        drive_AB;
  logic        dma_grant;
  logic        cpu_ready;
  logic        dma_abort;
  logic [15:0] dma_cycles;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  maria_bus_arbiter dut (
    .sysclock      (clk),
    .reset_b       (rst_n),
    .sel_slow_clock(sel),
    .dma_req       (req),
    .dma_done      (done),
    .wsync_req     (ws),
    .line_start    (ls),
    .pclk0         (pclk0),
    .halt_b        (halt_b),
    .drive_AB      (drive_AB),
    .dma_grant     (dma_grant),
    .cpu_ready     (cpu_ready),
    .dma_abort     (dma_abort),
    .dma_cycles    (dma_cycles)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d required=%0d",
               nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // CPU cycles are tracked as absolute sysclock windows [start, end].
  int m_n, m_start, m_end;
  int m_phase, m_pulses, m_gcycles;
  bit m_abort, m_ready;
  int m_acc, m_last;

  always @(negedge clk) begin
    bit e_pclk;
    bit in_dma;
    int exp_dc;
    if (!rst_n) begin
      m_n = 0; m_start = 0; m_end = -1;
      m_phase = P_IDLE; m_pulses = 0; m_gcycles = 0;
      m_abort = 0; m_ready = 1; m_acc = 0; m_last = 0;
      e_pclk = 0;
    end else begin
      if (m_n == m_start)
        m_end = m_n - 1 +
          ((sel && m_phase != P_GRANT) ? SLOW : FAST);
      e_pclk = (m_n == m_end);
    end
`ifdef ARB_DMA_STATS_EN
    exp_dc = m_last;
`else
    exp_dc = 0;
`endif
    chk("mdl_pclk0", pclk0, e_pclk);
    chk("mdl_halt_b", halt_b, m_phase == P_IDLE);
    chk("mdl_drive_AB", drive_AB, m_phase == P_GRANT);
    chk("mdl_dma_grant", dma_grant, m_phase == P_GRANT);
    chk("mdl_dma_abort", dma_abort, m_abort);
    chk("mdl_cpu_ready", cpu_ready, m_ready);
    chk("mdl_dma_cycles", dma_cycles, exp_dc);
    if (rst_n) begin
      in_dma = (m_phase == P_GRANT);
      m_abort = 0;
      case (m_phase)
        P_IDLE: if (req) begin
          m_phase = P_HALT; m_pulses = 0;
        end
        P_HALT: if (!req) m_phase = P_REL;
          else if (e_pclk) begin
            m_pulses++;
            if (m_pulses == 2) begin
              m_phase = P_GRANT; m_gcycles = 0;
            end
          end
        P_GRANT: begin
          m_gcycles++;
          if (done || !req) m_phase = P_REL;
          else if (m_gcycles == TMO) begin
            m_phase = P_REL; m_abort = 1;
          end
        end
        default: m_phase = P_IDLE;
      endcase
      if (ws) m_ready = 0;
      else if (ls) m_ready = 1;
      m_acc = m_acc + int'(in_dma);
      if (m_acc > 65535) m_acc = 65535;
      if (ls) begin
        m_last = m_acc;
        m_acc = 0;
      end
      if (e_pclk) m_start = m_n + 1;
      m_n++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_pclk(output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!pclk0 && n < 20);
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!dma_grant && n < 40);
  endtask

  typedef struct packed {
    logic ws;
    logic ls;
    logic rdy;
  } rv_t;

  rv_t tbl[16];

  initial begin
    int n;
    tbl[0]  = '{1'b0, 1'b1, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 1'b0};

    // Reset state
    cyc(3);
    chk("rst_pclk0", pclk0, 0);
    chk("rst_halt_b", halt_b, 1);
    chk("rst_drive_AB", drive_AB, 0);
    chk("rst_dma_grant", dma_grant, 0);
    chk("rst_cpu_ready", cpu_ready, 1);
    chk("rst_dma_abort", dma_abort, 0);
    chk("rst_dma_cycles", dma_cycles, 0);
    rst_n = 1'b1;

    // Divider: fast, mid-cycle switch, slow, back to fast
    wait_pclk(n);
    chk("first_pclk_edges", n, 3);
    wait_pclk(n);
    chk("fast_period", n, 4);
    cyc(2);
    sel = 1'b1;
    wait_pclk(n);
    chk("midcycle_sel_ignored", n, 2);
    wait_pclk(n);
    chk("slow_period_a", n, 6);
    wait_pclk(n);
    chk("slow_period_b", n, 6);
    sel = 1'b0;
    wait_pclk(n);
    chk("fast_again", n, 4);

    // HALT -> GRANT -> RELEASE handshake
    req = 1'b1;
    cyc(1);
    chk("halt_low_next", halt_b, 0);
    chk("no_grant_yet", dma_grant, 0);
    wait_grant(n);
    chk("grant_after_2_pclk", n, 8);
    chk("drive_with_grant", drive_AB, 1);
    cyc(4);
    done = 1'b1;
    req  = 1'b0;
    cyc(1);
    done = 1'b0;
    chk("rel_grant_low", dma_grant, 0);
    chk("rel_drive_low", drive_AB, 0);
    chk("rel_halt_still_low", halt_b, 0);
    cyc(1);
    chk("idle_halt_high", halt_b, 1);

    // Grant timeout
    req = 1'b1;
    wait_grant(n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!dma_abort && n < TMO + 80);
    chk("abort_after_1024", n, TMO);
    chk("abort_grant_low", dma_grant, 0);
    chk("abort_halt_low", halt_b, 0);
    cyc(1);
    chk("abort_one_cycle", dma_abort, 0);
    chk("abort_idle_halt", halt_b, 1);
    cyc(1);
    chk("rehalt", halt_b, 0);
    req = 1'b0;
    cyc(3);

    // Asynchronous reset during GRANT
    req = 1'b1;
    wait_grant(n);
    cyc(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_drive_AB", drive_AB, 0);
    chk("arst_dma_grant", dma_grant, 0);
    chk("arst_halt_b", halt_b, 1);
    cyc(1);
    req = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(2);

    // 37-cycle grant within one line
    ls = 1'b1;
    cyc(1);
    ls  = 1'b0;
    req = 1'b1;
    wait_grant(n);
    cyc(36);
    done = 1'b1;
    req  = 1'b0;
    cyc(1);
    done = 1'b0;
    cyc(3);
    ls = 1'b1;
    cyc(1);
    ls = 1'b0;
`ifdef ARB_DMA_STATS_EN
    chk("stats_37", dma_cycles, 37);
`else
    chk("stats_tied_0", dma_cycles, 0);
`endif

    // cpu_ready vector table
    for (int i = 0; i < 16; i++) begin
      ws = tbl[i].ws;
      ls = tbl[i].ls;
      cyc(1);
      chk($sformatf("rdy_vec%0d", i), cpu_ready, tbl[i].rdy);
    end
    ws = 1'b0;
    ls = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      done = 1'b0;
      if ($urandom_range(0, 7) == 0) sel = ~sel;
      if (!req) begin
        if ($urandom_range(0, 19) == 0) req = 1'b1;
      end else if ($urandom_range(0, 59) == 0) begin
        req = 1'b0;
      end
      if (dma_grant && $urandom_range(0, 11) == 0) begin
        done = 1'b1;
        req  = 1'b0;
      end else if ($urandom_range(0, 49) == 0) begin
        done = 1'b1;
      end
      ws = ($urandom_range(0, 39) == 0);
      ls = ($urandom_range(0, 29) == 0);
      cyc(1);
    end
    done = 1'b0;
    ws   = 1'b0;
    ls   = 1'b0;
    req  = 1'b0;
    cyc(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
